// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable serial bit-pattern detector with overlap control and a saturating match counter.
// Optional feature macro SEQ_DETECT_MASK_EN adds a per-bit don't-care mask (pat_mask) captured with the pattern.
module seq_detect_prog #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] pattern,
`ifdef SEQ_DETECT_MASK_EN
    input  logic [PAT_LEN-1:0] pat_mask,
`endif
    input  logic               overlap_en,
    input  logic               inp_valid,
    input  logic               inp_bit,
    input  logic               cnt_clr,
    output logic               seq_seen,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat,
    output logic               armed
);

    localparam int                FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic {
        UNARMED,
        ARMED
    } state_t;

    state_t             state;
    logic [PAT_LEN-1:0] pat_q;
    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN-1:0] hist_next;
    logic [PAT_LEN-1:0] cmp_mask;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_next;
    logic               shift_en;
    logic               match_hit;
    logic               sat_next;

`ifdef SEQ_DETECT_MASK_EN
    logic [PAT_LEN-1:0] mask_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
        end else if (cfg_load) begin
            mask_q <= pat_mask;
        end
    end

    assign cmp_mask = mask_q;
`else
    assign cmp_mask = '0;
`endif

    // A bit is only consumed while armed; a concurrent cfg_load discards it.
    assign shift_en  = (state == ARMED) && inp_valid && !cfg_load;
    assign hist_next = {hist[PAT_LEN-2:0], inp_bit};
    assign fill_next = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
    assign match_hit = shift_en && (fill_next == FILL_FULL) &&
                       (((hist_next ^ pat_q) & ~cmp_mask) == '0);
    assign sat_next  = (match_count == CNT_MAX) || (match_count == (CNT_MAX - CNT_ONE));
    assign armed     = (state == ARMED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= UNARMED;
            pat_q <= '0;
            hist  <= '0;
            fill  <= '0;
        end else if (cfg_load) begin
            state <= ARMED;
            pat_q <= pattern;
            hist  <= '0;
            fill  <= '0;
        end else if (shift_en) begin
            // Non-overlapping mode restarts from an empty history after a hit.
            if (match_hit && !overlap_en) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= hist_next;
                fill <= fill_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq_seen    <= 1'b0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else begin
            seq_seen <= match_hit;
            if (cnt_clr) begin
                match_count <= '0;
                count_sat   <= 1'b0;
            end else if (match_hit) begin
                if (match_count != CNT_MAX) begin
                    match_count <= match_count + CNT_ONE;
                end
                if (sat_next) begin
                    count_sat <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: table-driven scoreboard bench for seq_detect_prog (PAT_LEN=4, CNT_W=3).
// Honours SEQ_DETECT_MASK_EN so the same bench covers both builds.
module tb_seq_detect_prog;

    localparam int PAT_LEN = 4;
    localparam int CNT_W   = 3;
`ifdef SEQ_DETECT_MASK_EN
    localparam bit MASKED = 1'b1;
`else
    localparam bit MASKED = 1'b0;
`endif
    localparam logic [2:0] MC = MASKED ? 3'd1 : 3'd0;

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_load;
    logic [PAT_LEN-1:0] pattern;
    logic [PAT_LEN-1:0] pat_mask;
    logic               overlap_en;
    logic               inp_valid;
    logic               inp_bit;
    logic               cnt_clr;
    logic               seq_seen;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;
    logic               armed;

    always #5 clk = ~clk;

    seq_detect_prog #(
        .PAT_LEN(PAT_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_load   (cfg_load),
        .pattern    (pattern),
`ifdef SEQ_DETECT_MASK_EN
        .pat_mask   (pat_mask),
`endif
        .overlap_en (overlap_en),
        .inp_valid  (inp_valid),
        .inp_bit    (inp_bit),
        .cnt_clr    (cnt_clr),
        .seq_seen   (seq_seen),
        .match_count(match_count),
        .count_sat  (count_sat),
        .armed      (armed)
    );

    typedef struct {
        logic       load;
        logic [3:0] pat;
        logic [3:0] msk;
        logic       ovl;
        logic       vld;
        logic       din;
        logic       clr;
    } stim_t;

    typedef struct {
        logic       seen;
        logic [2:0] cnt;
        logic       sat;
        logic       arm;
    } resp_t;

    typedef struct {
        stim_t s;
        resp_t r;
    } vec_t;

    vec_t  tbl[$];
    resp_t sb[$];
    int    compared   = 0;
    int    mismatched = 0;
    int    split_idx  = 0;

    function automatic void put(logic ld, logic [3:0] pat, logic [3:0] msk, logic ovl,
                                logic vld, logic din, logic clr,
                                logic es, logic [2:0] ec, logic esat, logic earm);
        vec_t v;
        v.s = '{load: ld, pat: pat, msk: msk, ovl: ovl, vld: vld, din: din, clr: clr};
        v.r = '{seen: es, cnt: ec, sat: esat, arm: earm};
        tbl.push_back(v);
    endfunction

    function automatic void ld(logic [3:0] pat, logic [3:0] msk, logic ovl, logic [2:0] ec, logic esat);
        put(1'b1, pat, msk, ovl, 1'b0, 1'b0, 1'b0, 1'b0, ec, esat, 1'b1);
    endfunction

    function automatic void bt(logic din, logic ovl, logic es, logic [2:0] ec, logic esat);
        put(1'b0, 4'b0000, 4'b0000, ovl, 1'b1, din, 1'b0, es, ec, esat, 1'b1);
    endfunction

    function automatic void gap(logic [2:0] ec, logic esat);
        put(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ec, esat, 1'b1);
    endfunction

    task automatic checkOutput(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        resp_t e;
        @(negedge clk);
        cfg_load   = v.s.load;
        pattern    = v.s.pat;
        pat_mask   = v.s.msk;
        overlap_en = v.s.ovl;
        inp_valid  = v.s.vld;
        inp_bit    = v.s.din;
        cnt_clr    = v.s.clr;
        sb.push_back(v.r);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard vec %0d: got empty queue expected entry", idx);
        end else begin
            e = sb.pop_front();
            checkOutput("seq_seen",    idx, 8'(seq_seen),    8'(e.seen));
            checkOutput("match_count", idx, 8'(match_count), 8'(e.cnt));
            checkOutput("count_sat",   idx, 8'(count_sat),   8'(e.sat));
            checkOutput("armed",       idx, 8'(armed),       8'(e.arm));
        end
    endtask

    initial begin
        reset      = 1'b0;
        cfg_load   = 1'b0;
        pattern    = '0;
        pat_mask   = '0;
        overlap_en = 1'b0;
        inp_valid  = 1'b0;
        inp_bit    = 1'b0;
        cnt_clr    = 1'b0;

        // Overlapping 1011 over 1011011: hits on bits 4 and 7
        ld(4'b1011, 4'b0000, 1'b1, 3'd0, 1'b0);
        bt(1, 1, 0, 3'd0, 0); bt(0, 1, 0, 3'd0, 0); bt(1, 1, 0, 3'd0, 0); bt(1, 1, 1, 3'd1, 0);
        bt(0, 1, 0, 3'd1, 0); bt(1, 1, 0, 3'd1, 0); bt(1, 1, 1, 3'd2, 0);
        // Non-overlapping: single hit
        ld(4'b1011, 4'b0000, 1'b0, 3'd2, 1'b0);
        bt(1, 0, 0, 3'd2, 0); bt(0, 0, 0, 3'd2, 0); bt(1, 0, 0, 3'd2, 0); bt(1, 0, 1, 3'd3, 0);
        bt(0, 0, 0, 3'd3, 0); bt(1, 0, 0, 3'd3, 0); bt(1, 0, 0, 3'd3, 0);
        // Prefix recovery 11011
        ld(4'b1011, 4'b0000, 1'b1, 3'd3, 1'b0);
        bt(1, 1, 0, 3'd3, 0); bt(1, 1, 0, 3'd3, 0); bt(0, 1, 0, 3'd3, 0); bt(1, 1, 0, 3'd3, 0);
        bt(1, 1, 1, 3'd4, 0);
        // Invalid gaps inside 1011
        ld(4'b1011, 4'b0000, 1'b1, 3'd4, 1'b0);
        bt(1, 1, 0, 3'd4, 0); gap(3'd4, 0); bt(0, 1, 0, 3'd4, 0); gap(3'd4, 0); gap(3'd4, 0);
        bt(1, 1, 0, 3'd4, 0); gap(3'd4, 0); bt(1, 1, 1, 3'd5, 0); gap(3'd5, 0);
        // cfg_load with a valid bit: bit discarded, so 1+011 must not match
        put(1'b1, 4'b1011, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1);
        bt(0, 1, 0, 3'd5, 0); bt(1, 1, 0, 3'd5, 0); bt(1, 1, 0, 3'd5, 0); bt(1, 1, 0, 3'd5, 0);
        // Back-to-back hits, saturation at 7, clear colliding with a hit
        ld(4'b1111, 4'b0000, 1'b1, 3'd5, 1'b0);
        bt(1, 1, 0, 3'd5, 0); bt(1, 1, 0, 3'd5, 0); bt(1, 1, 0, 3'd5, 0); bt(1, 1, 1, 3'd6, 0);
        bt(1, 1, 1, 3'd7, 1); bt(1, 1, 1, 3'd7, 1);
        put(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1);
        bt(1, 1, 1, 3'd1, 0);
        put(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
        // Mask 0100 makes 1111 match 1011 only in the masked build
        ld(4'b1011, 4'b0100, 1'b1, 3'd0, 1'b0);
        bt(1, 1, 0, 3'd0, 0); bt(1, 1, 0, 3'd0, 0); bt(1, 1, 0, 3'd0, 0); bt(1, 1, MASKED, MC, 0);
        // Build up state before an asynchronous reset
        ld(4'b1011, 4'b0000, 1'b1, MC, 1'b0);
        bt(1, 1, 0, MC, 0); bt(0, 1, 0, MC, 0); bt(1, 1, 0, MC, 0); bt(1, 1, 1, MC + 3'd1, 0);
        bt(0, 1, 0, MC + 3'd1, 0); bt(1, 1, 0, MC + 3'd1, 0);
        split_idx = tbl.size();
        // After reset: bits ignored until reload, then normal detection
        for (int i = 0; i < 4; i++) begin
            put(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, (i != 1), 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        end
        ld(4'b1011, 4'b0000, 1'b1, 3'd0, 1'b0);
        bt(1, 1, 0, 3'd0, 0); bt(0, 1, 0, 3'd0, 0); bt(1, 1, 0, 3'd0, 0); bt(1, 1, 1, 3'd1, 0);

        repeat (2) @(negedge clk);
        checkOutput("reset_seq_seen",    -1, 8'(seq_seen),    8'd0);
        checkOutput("reset_match_count", -1, 8'(match_count), 8'd0);
        checkOutput("reset_count_sat",   -1, 8'(count_sat),   8'd0);
        checkOutput("reset_armed",       -1, 8'(armed),       8'd0);
        reset = 1'b1;

        for (int i = 0; i < split_idx; i++) begin
            applyStimulus(tbl[i], i);
        end

        @(negedge clk);
        cfg_load  = 1'b0;
        inp_valid = 1'b0;
        cnt_clr   = 1'b0;
        reset     = 1'b0;
        #1;
        checkOutput("async_rst_seq_seen",    -2, 8'(seq_seen),    8'd0);
        checkOutput("async_rst_match_count", -2, 8'(match_count), 8'd0);
        checkOutput("async_rst_count_sat",   -2, 8'(count_sat),   8'd0);
        checkOutput("async_rst_armed",       -2, 8'(armed),       8'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = split_idx; i < tbl.size(); i++) begin
            applyStimulus(tbl[i], i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Programmable serial bit-pattern detector; the parametrised successor to the fixed 4-bit sequence detectors in this design. It accepts one qualified bit per cycle and compares a shift-register history against a runtime-loaded pattern of PAT_LEN bits. It supports overlapping and non-overlapping match modes and keeps a saturating match counter. It sits between the serial input sampler and the event/status logic.

## Interface
- PAT_LEN, 4, pattern length in bits (2..16); first-received bit is compared against pattern[PAT_LEN-1]
- CNT_W, 8, width of match counter (1..16)
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- cfg_load  input  1  pulse: capture pattern, arm detector, flush history
- pattern  input  PAT_LEN  pattern to detect, MSB = oldest bit
- overlap_en  input  1  1 = overlapping matches allowed, 0 = history flushed after each match
- inp_valid  input  1  qualifies inp_bit this cycle
- inp_bit  input  1  serial data bit
- cnt_clr  input  1  pulse: clear match_count and count_sat
- seq_seen  output  1  registered one-cycle pulse per match
- match_count  output  CNT_W  saturating number of matches since reset/cnt_clr
- count_sat  output  1  sticky; high once match_count reaches 2^CNT_W-1
- armed  output  1  high when a pattern is loaded and detection is active

## Operation
- Registers: pat_q[PAT_LEN], hist[PAT_LEN], fill counter (0..PAT_LEN, saturates at PAT_LEN), 2-state FSM, match_count, count_sat, seq_seen.
- FSM UNARMED: inp_valid ignored, no history updates, armed=0. cfg_load -> ARMED.
- FSM ARMED: armed=1. cfg_load while ARMED: reload pat_q, hist=0, fill=0, stay ARMED.
- On a valid bit in ARMED: hist <= {hist[PAT_LEN-2:0], inp_bit}; fill <= min(fill+1, PAT_LEN).
- Match condition is evaluated on the post-shift history: new fill == PAT_LEN and new hist == pat_q (masked, see Configuration).
- On match: seq_seen=1 next cycle; match_count += 1 unless already all-ones; count_sat set when count becomes or is all-ones.
- overlap_en=1: history retained after a match, so 1011 detects in 1011011 twice.
- overlap_en=0: on match, fill <= 0 and hist <= 0; the next match needs PAT_LEN fresh bits.
- overlap_en is sampled each valid bit; changing it mid-stream affects only subsequent matches.
- inp_valid=0: no shift, no fill change, seq_seen=0.

## Timing
- Reset values: seq_seen=0, match_count=0, count_sat=0, armed=0, pat_q=0, hist=0, fill=0, FSM=UNARMED.
- Reset asserted mid-stream clears everything immediately (asynchronous); pattern must be reloaded.
- Latency: the bit sampled at edge k that completes the pattern gives seq_seen high from edge k until edge k+1.
- Back-to-back matches (overlap, periodic pattern such as 11) give seq_seen high on consecutive cycles.
- cfg_load and inp_valid in the same cycle: cfg_load wins; the bit is discarded; no match that cycle.
- cnt_clr and a match in the same cycle: clear wins (match_count=0, count_sat=0); seq_seen still pulses.
- armed rises the cycle after cfg_load.

## Configuration
- SEQ_DETECT_MASK_EN defined: adds input pat_mask [PAT_LEN] captured with pattern on cfg_load. A mask bit of 1 makes that position don't-care: the compare is ((hist ^ pat_q) & ~mask_q) == 0. Reset value of mask_q is 0.
- Not defined: there is no pat_mask port and every bit is compared exactly.

## Test plan
- PAT_LEN=4, load 1011, overlap_en=1, stream 1,0,1,1,0,1,1 -> seq_seen pulses after the 4th and 7th bits; match_count=2.
- Same stream with overlap_en=0 -> single pulse after the 4th bit; match_count=1.
- Load 1011, stream 1,1,0,1,1 -> one pulse after the 5th bit (prefix recovery).
- Insert inp_valid=0 gaps inside 1,0,1,1 -> pulse only after the last valid bit. Assert reset mid-stream -> outputs return to 0, armed=0, and further bits are ignored until cfg_load.
- CNT_W=2, six matches -> match_count=3, count_sat=1. cnt_clr coinciding with a match -> match_count=0 and seq_seen=1.
- With SEQ_DETECT_MASK_EN defined: pattern 1011, mask 0100, stream 1,1,1,1 -> match. Without the macro, the same stream gives no match.
